// File: rtl/mat_mult_lanes.sv
// Square signed matrix multiply C = A * B over external synchronous memories.
// LANES accumulators compute LANES adjacent C elements of one row per DIM-cycle pass.
module mat_mult_lanes #(
    parameter  int DW    = 8,
    parameter  int DIM   = 8,
    parameter  int LANES = 2,
    localparam int AW    = $clog2(DIM * DIM),
    localparam int ACCW  = 2 * DW + $clog2(DIM)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    output logic [AW-1:0]           a_addr_o,
    input  logic [DW-1:0]           a_data_i,
    output logic [LANES*AW-1:0]     b_addr_o,
    input  logic [LANES*DW-1:0]     b_data_i,
    output logic                    c_we_o,
    output logic [AW-1:0]           c_addr_o,
    output logic signed [ACCW-1:0]  c_data_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [15:0]             clock_count_o
);

    localparam int IW = $clog2(DIM);
    localparam int WW = (LANES > 1) ? $clog2(LANES) : 1;

    if (DIM < 2 || DIM > 64 || (DIM % LANES) != 0) begin : g_bad_params
        $error("mat_mult_lanes: DIM must be 2..64 and a multiple of LANES");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [IW-1:0]          i_q;
    logic [IW-1:0]          j0_q;
    logic [IW-1:0]          k_q;
    logic [WW-1:0]          w_q;
    logic [AW-1:0]          a_addr_q;
    logic [LANES*AW-1:0]    b_addr_q;
    logic                   c_we_q;
    logic [AW-1:0]          c_addr_q;
    logic signed [ACCW-1:0] c_data_q;
    logic                   busy_q;
    logic                   done_q;
    logic [15:0]            cnt_q;

    logic signed [ACCW-1:0] acc_rd [LANES];
    logic signed [ACCW-1:0] acc_d  [LANES];
    logic signed [ACCW-1:0] c_next;
    logic                   acc_en;
    logic                   acc_load;

    function automatic logic [AW-1:0] lin_addr(input int row, input int col);
        return AW'(row * DIM + col);
    endfunction

    function automatic logic [LANES*AW-1:0] b_lane_addrs(input int k, input int j0);
        logic [LANES*AW-1:0] v;
        v = '0;
        for (int l = 0; l < LANES; l++) begin
            v[l*AW +: AW] = lin_addr(k, j0 + l);
        end
        return v;
    endfunction

    // Read data lags the address by one cycle, so the k=0 product arrives
    // while k=1 is being presented and the last product arrives in LAST.
    assign acc_en   = (state_q == S_FETCH && k_q != '0) || (state_q == S_LAST);
    assign acc_load = (state_q == S_FETCH) && (k_q == IW'(1));

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [2*DW-1:0] prod;
        logic signed [ACCW-1:0] acc_q;

        assign prod       = $signed(a_data_i) * $signed(b_data_i[gi*DW +: DW]);
        assign acc_d[gi]  = acc_load ? ACCW'(prod) : acc_q + ACCW'(prod);
        assign acc_rd[gi] = acc_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                acc_q <= '0;
            end else if (acc_en) begin
                acc_q <= acc_d[gi];
            end
        end
    end

    always_comb begin
        c_next = '0;
        for (int l = 1; l < LANES; l++) begin
            if (int'(w_q) + 1 == l) begin
                c_next = acc_rd[l];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            j0_q     <= '0;
            k_q      <= '0;
            w_q      <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            c_we_q   <= 1'b0;
            c_addr_q <= '0;
            c_data_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (busy_q && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q  <= S_FETCH;
                        i_q      <= '0;
                        j0_q     <= '0;
                        k_q      <= '0;
                        w_q      <= '0;
                        a_addr_q <= '0;
                        b_addr_q <= b_lane_addrs(0, 0);
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        cnt_q    <= '0;
                    end
                end
                S_FETCH: begin
                    if (k_q == IW'(DIM - 1)) begin
                        state_q <= S_LAST;
                    end else begin
                        k_q      <= k_q + IW'(1);
                        a_addr_q <= lin_addr(int'(i_q), int'(k_q) + 1);
                        b_addr_q <= b_lane_addrs(int'(k_q) + 1, int'(j0_q));
                    end
                end
                S_LAST: begin
                    // Lane 0 finishes accumulating on this edge, so take its next value.
                    state_q  <= S_WRITE;
                    w_q      <= '0;
                    c_we_q   <= 1'b1;
                    c_addr_q <= lin_addr(int'(i_q), int'(j0_q));
                    c_data_q <= acc_d[0];
                end
                S_WRITE: begin
                    if (int'(w_q) != LANES - 1) begin
                        w_q      <= w_q + WW'(1);
                        c_addr_q <= c_addr_q + AW'(1);
                        c_data_q <= c_next;
                    end else begin
                        c_we_q <= 1'b0;
                        k_q    <= '0;
                        if (int'(j0_q) + LANES == DIM) begin
                            j0_q <= '0;
                            if (int'(i_q) == DIM - 1) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q  <= S_FETCH;
                                i_q      <= i_q + IW'(1);
                                a_addr_q <= lin_addr(int'(i_q) + 1, 0);
                                b_addr_q <= b_lane_addrs(0, 0);
                            end
                        end else begin
                            state_q  <= S_FETCH;
                            j0_q     <= j0_q + IW'(LANES);
                            a_addr_q <= lin_addr(int'(i_q), 0);
                            b_addr_q <= b_lane_addrs(0, int'(j0_q) + LANES);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign a_addr_o      = a_addr_q;
    assign b_addr_o      = b_addr_q;
    assign c_we_o        = c_we_q;
    assign c_addr_o      = c_addr_q;
    assign c_data_o      = c_data_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign clock_count_o = cnt_q;

endmodule

// File: tb/tb_mat_mult_lanes.sv
// Runs three lane configurations (2, 1, 8) on shared A/B memories and checks
// every C write, latency and clock_count against a plain matrix-product model.
module tb_mat_mult_lanes;

    localparam int DW   = 8;
    localparam int DIM  = 8;
    localparam int AW   = 6;
    localparam int ACCW = 19;
    localparam int NI   = 3;
    localparam int NE   = DIM * DIM;

    logic clk = 1'b0;
    logic rst_n;
    logic start [NI];

    logic                   c_we_w   [NI];
    logic [AW-1:0]          a_addr_w [NI];
    logic [AW-1:0]          c_addr_w [NI];
    logic signed [ACCW-1:0] c_data_w [NI];
    logic                   busy_w   [NI];
    logic                   done_w   [NI];
    logic [15:0]            cnt_w    [NI];
    logic                   b_zero   [NI];

    logic signed [DW-1:0] a_mem [NE];
    logic signed [DW-1:0] b_mem [NE];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 2 : (gi == 1) ? 1 : 8;
        logic [L*AW-1:0] b_addr;
        logic [L*DW-1:0] b_data;
        logic [DW-1:0]   a_data;

        mat_mult_lanes #(.DW(DW), .DIM(DIM), .LANES(L)) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n),
            .start_i       (start[gi]),
            .a_addr_o      (a_addr_w[gi]),
            .a_data_i      (a_data),
            .b_addr_o      (b_addr),
            .b_data_i      (b_data),
            .c_we_o        (c_we_w[gi]),
            .c_addr_o      (c_addr_w[gi]),
            .c_data_o      (c_data_w[gi]),
            .busy_o        (busy_w[gi]),
            .done_o        (done_w[gi]),
            .clock_count_o (cnt_w[gi])
        );

        assign b_zero[gi] = (b_addr == '0);

        always @(posedge clk) begin
            a_data <= a_mem[a_addr_w[gi]];
            for (int l = 0; l < L; l++) begin
                b_data[l*DW +: DW] <= b_mem[b_addr[l*AW +: AW]];
            end
        end
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_cyc [NI];
    int done_cyc  [NI];
    int done_cnt  [NI];
    int writes    [NI];
    bit active    [NI];
    bit written   [NI][NE];
    int cref      [NE];

    function automatic int exp_lat(input int g);
        return (g == 0) ? 352 : (g == 1) ? 640 : 136;
    endfunction

    task automatic chk(input int g, input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL inst%0d %s: got %0d expected %0d", g, name, act, exp);
        end
    endtask

    task automatic compute_ref();
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                int s;
                s = 0;
                for (int k = 0; k < DIM; k++) begin
                    s += int'(a_mem[r*DIM+k]) * int'(b_mem[k*DIM+c]);
                end
                cref[r*DIM+c] = s;
            end
        end
    endtask

    task automatic fill_random();
        for (int n = 0; n < NE; n++) begin
            a_mem[n] = 8'($urandom_range(0, 255));
            b_mem[n] = 8'($urandom_range(0, 255));
        end
        compute_ref();
    endtask

    task automatic check_all();
        for (int g = 0; g < NI; g++) begin
            if (c_we_w[g]) begin
                chk(g, active[g], "c_we_outside_run", 1, 0);
                if (active[g]) begin
                    int a;
                    a = int'(c_addr_w[g]);
                    chk(g, !written[g][a], "c_addr_written_twice", a, -1);
                    written[g][a] = 1'b1;
                    writes[g]++;
                    chk(g, int'(c_data_w[g]) == cref[a], "c_data", int'(c_data_w[g]), cref[a]);
                end
            end
            chk(g, !(done_w[g] && busy_w[g]), "done_and_busy", 1, 0);
            if (active[g] && busy_w[g]) begin
                chk(g, int'(cnt_w[g]) == cyc - start_cyc[g], "clock_count_running",
                    int'(cnt_w[g]), cyc - start_cyc[g]);
            end
            if (active[g] && done_w[g] && done_cyc[g] < 0) begin
                done_cyc[g] = cyc - start_cyc[g];
                done_cnt[g] = int'(cnt_w[g]);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic begin_run(input int g);
        active[g]    = 1'b1;
        start_cyc[g] = cyc;
        done_cyc[g]  = -1;
        writes[g]    = 0;
        for (int n = 0; n < NE; n++) written[g][n] = 1'b0;
    endtask

    task automatic launch(input int mask, input bit hold);
        for (int g = 0; g < NI; g++) if (mask[g]) start[g] = 1'b1;
        tick();
        for (int g = 0; g < NI; g++) begin
            if (mask[g]) begin
                begin_run(g);
                if (!hold) start[g] = 1'b0;
            end
        end
    endtask

    function automatic bit all_done(input int mask);
        for (int g = 0; g < NI; g++) begin
            if (mask[g] && done_cyc[g] < 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_done(input int mask);
        int guard;
        guard = 0;
        while (!all_done(mask) && guard < 2000) begin
            tick();
            guard++;
        end
        for (int g = 0; g < NI; g++) begin
            if (mask[g]) begin
                chk(g, done_cyc[g] >= 0, "done_timeout", done_cyc[g], exp_lat(g));
                chk(g, done_cyc[g] == exp_lat(g), "latency", done_cyc[g], exp_lat(g));
                chk(g, done_cnt[g] == exp_lat(g), "clock_count_at_done", done_cnt[g], exp_lat(g));
                chk(g, writes[g] == NE, "c_we_pulses", writes[g], NE);
                active[g] = 1'b0;
            end
        end
    endtask

    task automatic settle(input int mask);
        tick();
        tick();
        for (int g = 0; g < NI; g++) begin
            if (mask[g]) begin
                chk(g, done_w[g] == 1'b1, "done_level_held", int'(done_w[g]), 1);
                chk(g, busy_w[g] == 1'b0, "busy_after_done", int'(busy_w[g]), 0);
                chk(g, int'(cnt_w[g]) == exp_lat(g), "clock_count_hold", int'(cnt_w[g]), exp_lat(g));
            end
        end
    endtask

    task automatic check_reset_state();
        for (int g = 0; g < NI; g++) begin
            chk(g, c_we_w[g] == 1'b0, "rst_c_we", int'(c_we_w[g]), 0);
            chk(g, busy_w[g] == 1'b0, "rst_busy", int'(busy_w[g]), 0);
            chk(g, done_w[g] == 1'b0, "rst_done", int'(done_w[g]), 0);
            chk(g, cnt_w[g] == 16'd0, "rst_clock_count", int'(cnt_w[g]), 0);
            chk(g, a_addr_w[g] == '0, "rst_a_addr", int'(a_addr_w[g]), 0);
            chk(g, c_addr_w[g] == '0, "rst_c_addr", int'(c_addr_w[g]), 0);
            chk(g, c_data_w[g] == '0, "rst_c_data", int'(c_data_w[g]), 0);
            chk(g, b_zero[g] == 1'b1, "rst_b_addr_zero", int'(b_zero[g]), 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < NI; g++) begin
            start[g]    = 1'b0;
            active[g]   = 1'b0;
            done_cyc[g] = -1;
        end
        for (int n = 0; n < NE; n++) begin
            a_mem[n] = '0;
            b_mem[n] = '0;
        end
        compute_ref();

        repeat (3) tick();
        check_reset_state();
        rst_n = 1'b1;

        // Identity A, ramp B: C must reproduce B.
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                a_mem[r*DIM+c] = (r == c) ? 8'sd1 : 8'sd0;
                b_mem[r*DIM+c] = 8'(r * 8 + c - 32);
            end
        end
        compute_ref();
        chk(0, cref[0] == -32, "model_identity_c0", cref[0], -32);
        chk(0, cref[9] == -23, "model_identity_c9", cref[9], -23);
        chk(0, cref[63] == 31, "model_identity_c63", cref[63], 31);
        launch(7, 1'b0);
        wait_done(7);
        settle(7);

        for (int n = 0; n < NE; n++) begin
            a_mem[n] = -8'sd128;
            b_mem[n] = -8'sd128;
        end
        compute_ref();
        chk(0, cref[27] == 131072, "model_neg_neg", cref[27], 131072);
        launch(7, 1'b0);
        wait_done(7);

        for (int n = 0; n < NE; n++) b_mem[n] = 8'sd127;
        compute_ref();
        chk(0, cref[50] == -130048, "model_neg_pos", cref[50], -130048);
        launch(7, 1'b0);
        wait_done(7);

        for (int t = 0; t < 3; t++) begin
            fill_random();
            launch(7, 1'b0);
            wait_done(7);
        end

        // Start re-pulsed mid-run must be ignored.
        fill_random();
        launch(1, 1'b0);
        while (cyc - start_cyc[0] < 4) tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        while (cyc - start_cyc[0] < 199) tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_done(1);
        settle(1);

        // Reset in the middle of a run, then a fresh run.
        fill_random();
        launch(7, 1'b0);
        while (cyc - start_cyc[0] < 99) tick();
        rst_n = 1'b0;
        for (int g = 0; g < NI; g++) active[g] = 1'b0;
        #1;
        check_reset_state();
        while (cyc - start_cyc[0] < 102) tick();
        rst_n = 1'b1;
        while (cyc - start_cyc[0] < 109) tick();
        launch(7, 1'b0);
        wait_done(7);

        // Start held high across done restarts immediately.
        fill_random();
        launch(1, 1'b1);
        wait_done(1);
        tick();
        chk(0, done_w[0] == 1'b0, "restart_done_drop", int'(done_w[0]), 0);
        chk(0, busy_w[0] == 1'b1, "restart_busy", int'(busy_w[0]), 1);
        chk(0, cnt_w[0] == 16'd0, "restart_clock_count", int'(cnt_w[0]), 0);
        begin_run(0);
        start[0] = 1'b0;
        wait_done(1);
        settle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mat_mult_lanes.md
MAT_MULT_LANES -- requirements
Module: mat_mult_lanes

Interface
REQ-001 SHALL have parameter DW, default 8, meaning signed element width of A and B.
REQ-002 SHALL have parameter DIM, default 8, meaning side length of square matrices A, B and C; legal range 2..64.
REQ-003 SHALL have parameter LANES, default 2, meaning parallel MAC lanes; DIM mod LANES = 0 is required, else elaboration SHALL fail.
REQ-004 SHALL derive AW = clog2(DIM*DIM) and ACCW = 2*DW + clog2(DIM); these are local, not overridable.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  launch request, sampled on the rising edge.
REQ-008 a_addr  output  AW  read address into external A memory, row-major.
REQ-009 a_data  input  DW  signed A word, valid one cycle after a_addr.
REQ-010 b_addr  output  LANES*AW  packed per-lane B read addresses, lane l in bits [l*AW +: AW].
REQ-011 b_data  input  LANES*DW  packed signed B words, valid one cycle after b_addr.
REQ-012 c_we  output  1  write strobe to external C memory.
REQ-013 c_addr  output  AW  C write address, row-major.
REQ-014 c_data  output  ACCW  signed C element.
REQ-015 busy  output  1  high from the cycle after an accepted start until done rises.
REQ-016 done  output  1  level; high after the final C write, cleared by the next accepted start.
REQ-017 clock_count  output  16  busy-cycle counter.

Function
REQ-018 SHALL implement states IDLE, FETCH, LAST, WRITE, DONE; DONE behaves like IDLE for start acceptance.
REQ-019 start in IDLE or DONE SHALL be accepted: i=0, j0=0, k=0, done=0, clock_count=0, next state FETCH.
REQ-020 start in FETCH, LAST or WRITE SHALL be ignored.
REQ-021 FETCH SHALL last DIM cycles, presenting a_addr = i*DIM+k and lane l b_addr = k*DIM+j0+l for k = 0..DIM-1.
REQ-022 Each lane accumulator SHALL load (not add) the product a_data*b_data[l] one cycle after k=0 is presented, and add it for k>0.
REQ-023 LAST SHALL be one cycle that accumulates the k=DIM-1 data; addresses are don't-care.
REQ-024 WRITE SHALL last LANES cycles; cycle w drives c_we=1, c_addr = i*DIM+j0+w, c_data = lane w accumulator.
REQ-025 After WRITE, j0 SHALL advance by LANES; at j0 = DIM it SHALL wrap to 0 and i SHALL increment; if i was DIM-1, go to DONE, else return to FETCH.
REQ-026 Products SHALL be full-precision signed 2*DW; accumulation SHALL be signed ACCW with no saturation (ACCW is sized so overflow cannot occur).
REQ-027 Total latency from accepted start to done high SHALL be (DIM*DIM/LANES)*(DIM+1+LANES) cycles; for defaults this is 352.
REQ-028 clock_count SHALL increment every cycle busy is high, saturate at 16'hFFFF, and hold its value while in DONE.
REQ-029 c_we SHALL be high only in WRITE; each C address SHALL be written exactly once per run.
REQ-030 done and busy SHALL never be high together.

Reset
REQ-031 reset low SHALL immediately force IDLE and set busy=0, done=0, c_we=0, clock_count=0, a_addr=0, b_addr=0, c_addr=0, c_data=0, and all accumulators and indices to 0.
REQ-032 Reset asserted mid-run SHALL abort the run with no further c_we pulses; a new start after release SHALL run from i=0, j0=0.
REQ-033 The first rising edge after reset release SHALL be able to accept start.

Verification
REQ-034 Defaults, A = identity, B(r,c) = r*8+c-32 -> C equals B at all 64 addresses; done at cycle 352; clock_count = 352.
REQ-035 Defaults, all A = B = -128 -> every c_data = 131072 (19'sh20000); all A = -128, all B = 127 -> every c_data = -130048.
REQ-036 start re-pulsed at cycles 5 and 200 of a run -> ignored; exactly 64 c_we pulses; done at cycle 352.
REQ-037 reset low at cycle 100, released at cycle 103, start at 110 -> no c_we during 100..110; the fresh run completes 352 cycles after 110 with correct C.
REQ-038 LANES=1 and LANES=DIM=8 builds, random signed A, B -> C matches a reference model; latencies 640 and 136 cycles.
REQ-039 start held high across done -> a second run begins the cycle after entering DONE; done drops; clock_count restarts from 0.
